// File: rtl/pipe_pkg.sv
// Shared types for the decode/execute pipeline slice.
// Register index, data word and the ID/EX payload bundle.
package pipe_pkg;

  typedef logic [4:0]  reg_idx_t;
  typedef logic [63:0] xlen_t;

  localparam reg_idx_t    XZR        = 5'd31;
  localparam int unsigned CTRL_DEF_W = 16;

  typedef struct packed {
    reg_idx_t              rd;
    logic                  wr_en;
    logic                  is_load;
    xlen_t                 imm;
    logic [CTRL_DEF_W-1:0] ctrl;
  } id_ex_t;

  function automatic logic src_hit(
    input logic     v,
    input reg_idx_t r,
    input reg_idx_t s
  );
    return v && (r == s);
  endfunction

endpackage

// File: rtl/operand_bypass_mux.sv
// Per-source operand select: zero register, then EX/MEM,
// then writeback, then register file.
module operand_bypass_mux
  import pipe_pkg::*;
(
  input  reg_idx_t src_i,
  input  xlen_t    rf_data_i,
  input  logic     fwd_valid_i,
  input  reg_idx_t fwd_reg_i,
  input  xlen_t    fwd_data_i,
  input  logic     wb_valid_i,
  input  reg_idx_t wb_reg_i,
  input  xlen_t    wb_data_i,
  output xlen_t    op_o
);

  always_comb begin
    op_o = rf_data_i;
    if (src_i == XZR)
      op_o = '0;
    else if (src_hit(fwd_valid_i, fwd_reg_i, src_i))
      op_o = fwd_data_i;
    else if (src_hit(wb_valid_i, wb_reg_i, src_i))
      op_o = wb_data_i;
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch: RF read, bypass, load-use bubble and
// the ID/EX pipeline register with valid/ready handshakes.
module operand_fetch_stage
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_rn,
  input  logic [4:0]        in_rm,
  input  logic [4:0]        in_rd,
  input  logic              in_wr_en,
  input  logic              in_is_load,
  input  logic [63:0]       in_imm,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic [4:0]        rf_read_reg1,
  output logic [4:0]        rf_read_reg2,
  input  logic [63:0]       rf_read_data1,
  input  logic [63:0]       rf_read_data2,
  input  logic              fwd_valid,
  input  logic [4:0]        fwd_reg,
  input  logic [63:0]       fwd_data,
  input  logic              wb_valid,
  input  logic [4:0]        wb_reg,
  input  logic [63:0]       wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_op1,
  output logic [63:0]       out_op2,
  output logic [4:0]        out_rd,
  output logic              out_wr_en,
  output logic              out_is_load,
  output logic [63:0]       out_imm,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic             valid_q, valid_d;
  id_ex_t           pay_q, pay_d;
  xlen_t            op1_q, op1_d;
  xlen_t            op2_q, op2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  xlen_t op1, op2;
  logic  hz, accept, src_dep;

  assign rf_read_reg1 = in_rn;
  assign rf_read_reg2 = in_rm;

  operand_bypass_mux u_mux1 (
    .src_i      (in_rn),
    .rf_data_i  (rf_read_data1),
    .fwd_valid_i(fwd_valid),
    .fwd_reg_i  (fwd_reg),
    .fwd_data_i (fwd_data),
    .wb_valid_i (wb_valid),
    .wb_reg_i   (wb_reg),
    .wb_data_i  (wb_data),
    .op_o       (op1)
  );

  operand_bypass_mux u_mux2 (
    .src_i      (in_rm),
    .rf_data_i  (rf_read_data2),
    .fwd_valid_i(fwd_valid),
    .fwd_reg_i  (fwd_reg),
    .fwd_data_i (fwd_data),
    .wb_valid_i (wb_valid),
    .wb_reg_i   (wb_reg),
    .wb_data_i  (wb_data),
    .op_o       (op2)
  );

  assign src_dep = (in_rn == pay_q.rd) ||
                   (in_rm == pay_q.rd);

  assign hz = in_valid && valid_q &&
              pay_q.is_load && pay_q.wr_en &&
              (pay_q.rd != XZR) && src_dep;

  assign in_ready = (!valid_q || out_ready) &&
                    !hz && !flush;

  assign accept = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    pay_d   = pay_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    cnt_d   = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d       = 1'b1;
      pay_d.rd      = in_rd;
      pay_d.wr_en   = in_wr_en;
      pay_d.is_load = in_is_load;
      pay_d.imm     = in_imm;
      pay_d.ctrl    = CTRL_DEF_W'(in_ctrl);
      op1_d         = op1;
      op2_d         = op2;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
    // bubble: the load leaves while its consumer waits
    if (hz && out_ready && !(&cnt_q))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      pay_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pay_q   <= pay_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_op1     = op1_q;
  assign out_op2     = op2_q;
  assign out_rd      = pay_q.rd;
  assign out_wr_en   = pay_q.wr_en;
  assign out_is_load = pay_q.is_load;
  assign out_imm     = pay_q.imm;
  assign out_ctrl    = CTRL_W'(pay_q.ctrl);
  assign stall_cnt   = cnt_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Scoreboard bench for operand_fetch_stage: bypass priority,
// load-use bubble, backpressure, flush and reset.
module tb_operand_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [4:0]  in_rn, in_rm, in_rd;
  logic        in_wr_en, in_is_load;
  logic [63:0] in_imm;
  logic [15:0] in_ctrl;
  logic [4:0]  rf_read_reg1, rf_read_reg2;
  logic [63:0] rf_read_data1, rf_read_data2;
  logic        fwd_valid;
  logic [4:0]  fwd_reg;
  logic [63:0] fwd_data;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [63:0] wb_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [63:0] out_op1, out_op2;
  logic [4:0]  out_rd;
  logic        out_wr_en, out_is_load;
  logic [63:0] out_imm;
  logic [15:0] out_ctrl;
  logic [15:0] stall_cnt;

  typedef struct {
    logic [63:0] op1;
    logic [63:0] op2;
    logic [4:0]  rd;
    logic        wr;
    logic        ld;
    logic [63:0] imm;
    logic [15:0] ctrl;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] p_op1, p_op2;
  int          n_cmp = 0;
  int          n_bad = 0;

  operand_fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rn        (in_rn),
    .in_rm        (in_rm),
    .in_rd        (in_rd),
    .in_wr_en     (in_wr_en),
    .in_is_load   (in_is_load),
    .in_imm       (in_imm),
    .in_ctrl      (in_ctrl),
    .rf_read_reg1 (rf_read_reg1),
    .rf_read_reg2 (rf_read_reg2),
    .rf_read_data1(rf_read_data1),
    .rf_read_data2(rf_read_data2),
    .fwd_valid    (fwd_valid),
    .fwd_reg      (fwd_reg),
    .fwd_data     (fwd_data),
    .wb_valid     (wb_valid),
    .wb_reg       (wb_reg),
    .wb_data      (wb_data),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_op1      (out_op1),
    .out_op2      (out_op2),
    .out_rd       (out_rd),
    .out_wr_en    (out_wr_en),
    .out_is_load  (out_is_load),
    .out_imm      (out_imm),
    .out_ctrl     (out_ctrl),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  // pops before pushes; reset and flush kill the stage contents
  always @(negedge clk) begin
    if (reset || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("op1",  out_op1, e.op1);
          check("op2",  out_op2, e.op2);
          check("rd",   64'(out_rd), 64'(e.rd));
          check("wr",   64'(out_wr_en), 64'(e.wr));
          check("ld",   64'(out_is_load), 64'(e.ld));
          check("imm",  out_imm, e.imm);
          check("ctrl", 64'(out_ctrl), 64'(e.ctrl));
        end
      end
      if (in_valid && in_ready) begin
        exp_t e;
        e.op1  = p_op1;
        e.op2  = p_op2;
        e.rd   = in_rd;
        e.wr   = in_wr_en;
        e.ld   = in_is_load;
        e.imm  = in_imm;
        e.ctrl = in_ctrl;
        sb.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setup(
    input logic [4:0]  rn, rm, rd,
    input logic        wr, ld,
    input logic [63:0] r1, r2, e1, e2
  );
    in_rn         = rn;
    in_rm         = rm;
    in_rd         = rd;
    in_wr_en      = wr;
    in_is_load    = ld;
    in_imm        = {32'h1000_0000, 27'd0, rd};
    in_ctrl       = {11'd0, rn} ^ 16'hA5A5;
    rf_read_data1 = r1;
    rf_read_data2 = r2;
    p_op1         = e1;
    p_op2         = e2;
  endtask

  task automatic send(
    input logic [4:0]  rn, rm, rd,
    input logic        wr, ld,
    input logic [63:0] r1, r2, e1, e2
  );
    bit ok;
    setup(rn, rm, rd, wr, ld, r1, r2, e1, e2);
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      step();
    end
    if (!ok) check("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    flush = 1'b0;
    fwd_valid = 1'b0;
    fwd_reg = '0;
    fwd_data = '0;
    wb_valid = 1'b0;
    wb_reg = '0;
    wb_data = '0;
    setup(5'd0, 5'd0, 5'd0, 1'b0, 1'b0,
          64'd0, 64'd0, 64'd0, 64'd0);
    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_cnt",   64'(stall_cnt), 64'd0);
    check("rst_op1",   out_op1, 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    step();

    // plain RF read
    send(5'd3, 5'd4, 5'd5, 1'b1, 1'b0,
         64'h5, 64'h6, 64'h5, 64'h6);
    @(negedge clk);
    check("lat1_valid", 64'(out_valid), 64'd1);
    check("lat1_op1", out_op1, 64'h5);
    check("rf_addr2", 64'(rf_read_reg2), 64'd4);
    step();

    // writeback bypass, then fwd beats wb
    wb_valid = 1'b1;
    wb_reg = 5'd3;
    wb_data = 64'hAA;
    send(5'd3, 5'd4, 5'd6, 1'b1, 1'b0,
         64'h11, 64'h22, 64'hAA, 64'h22);
    fwd_valid = 1'b1;
    fwd_reg = 5'd3;
    fwd_data = 64'hBB;
    send(5'd3, 5'd4, 5'd6, 1'b1, 1'b0,
         64'h11, 64'h22, 64'hBB, 64'h22);
    wb_valid = 1'b0;

    // zero register ignores the bypass
    fwd_reg = 5'd31;
    fwd_data = 64'hFF;
    send(5'd31, 5'd31, 5'd2, 1'b1, 1'b0,
         64'h33, 64'h44, 64'd0, 64'd0);
    fwd_reg = 5'd9;
    fwd_data = 64'h1234_5678_9ABC_DEF0;
    send(5'd9, 5'd9, 5'd2, 1'b1, 1'b0,
         64'h1, 64'h2, 64'h1234_5678_9ABC_DEF0,
         64'h1234_5678_9ABC_DEF0);
    fwd_valid = 1'b0;

    // load without wr_en: no hazard
    send(5'd1, 5'd2, 5'd7, 1'b0, 1'b1,
         64'h10, 64'h20, 64'h10, 64'h20);
    setup(5'd7, 5'd2, 5'd9, 1'b1, 1'b0,
          64'h70, 64'h20, 64'h70, 64'h20);
    in_valid = 1'b1;
    @(negedge clk);
    check("nowr_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;

    // load-use bubble
    send(5'd1, 5'd2, 5'd7, 1'b1, 1'b1,
         64'h10, 64'h20, 64'h10, 64'h20);
    setup(5'd7, 5'd2, 5'd9, 1'b1, 1'b0,
          64'h70, 64'h20, 64'hDEAD, 64'h20);
    in_valid = 1'b1;
    @(negedge clk);
    check("hz_ready", 64'(in_ready), 64'd0);
    step();
    fwd_valid = 1'b1;
    fwd_reg = 5'd7;
    fwd_data = 64'hDEAD;
    @(negedge clk);
    check("bub_valid", 64'(out_valid), 64'd0);
    check("bub_cnt", 64'(stall_cnt), 64'd1);
    check("bub_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    fwd_valid = 1'b0;

    // backpressure hold
    send(5'd1, 5'd2, 5'd3, 1'b1, 1'b0,
         64'hA1, 64'hA2, 64'hA1, 64'hA2);
    out_ready = 1'b0;
    setup(5'd4, 5'd5, 5'd6, 1'b1, 1'b0,
          64'h90, 64'h91, 64'h77, 64'h78);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_ready", 64'(in_ready), 64'd0);
      check("hold_op1", out_op1, 64'hA1);
      check("hold_rd", 64'(out_rd), 64'd3);
      step();
      rf_read_data1 = 64'h90 + 64'(i);
    end
    rf_read_data1 = 64'h77;
    rf_read_data2 = 64'h78;
    out_ready = 1'b1;
    @(negedge clk);
    check("rel_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("rel_op1", out_op1, 64'h77);
    step();

    // flush with an offered instruction
    send(5'd1, 5'd2, 5'd3, 1'b1, 1'b0,
         64'h1, 64'h2, 64'h1, 64'h2);
    out_ready = 1'b0;
    setup(5'd4, 5'd5, 5'd6, 1'b1, 1'b0,
          64'h4, 64'h5, 64'h4, 64'h5);
    in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    check("fl_ready", 64'(in_ready), 64'd0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_cnt", 64'(stall_cnt), 64'd1);
    step();
    @(negedge clk);
    check("fl_drop", 64'(out_valid), 64'd0);
    step();

    // reset during a load-use stall
    send(5'd1, 5'd2, 5'd8, 1'b1, 1'b1,
         64'h5, 64'h6, 64'h5, 64'h6);
    out_ready = 1'b0;
    setup(5'd8, 5'd1, 5'd9, 1'b1, 1'b0,
          64'h5, 64'h6, 64'h5, 64'h6);
    in_valid = 1'b1;
    @(negedge clk);
    check("st_ready", 64'(in_ready), 64'd0);
    step();
    reset = 1'b1;
    step();
    @(negedge clk);
    check("mrst_valid", 64'(out_valid), 64'd0);
    check("mrst_op1", out_op1, 64'd0);
    check("mrst_rd", 64'(out_rd), 64'd0);
    check("mrst_imm", out_imm, 64'd0);
    check("mrst_ctrl", 64'(out_ctrl), 64'd0);
    check("mrst_cnt", 64'(stall_cnt), 64'd0);
    step();
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
